recovery_regfile_ckpt: RTL

//  Parametrised recovery register file for the TMR RISC-V core: shadows every architectural register write.
//  Per-entry parity is stored with each register.
//  On restore_req (total collapse detected by the voter) it streams all registers back to the re-initialised cores.
//  The stream is one entry per handshake over a valid/ready channel.

---
 rtl/riscv_tmr_pkg.sv | 18 +
 rtl/recovery_restore_fsm.sv | 71 +++++++
 rtl/recovery_regfile_ckpt.sv | 100 ++++++++++
 3 files changed

// File: rtl/riscv_tmr_pkg.sv
// Shared definitions for the TMR RISC-V recovery logic.
package riscv_tmr_pkg;

    localparam int XLEN_D  = 32;
    localparam int NREGS_D = 32;

    typedef enum logic [1:0] {
        IDLE,
        RESTORE,
        DONE
    } rec_state_t;

    // Parity is computed over the default data width; instantiate with XLEN == XLEN_D.
    function automatic logic even_par(input logic [XLEN_D-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/recovery_restore_fsm.sv
// Restore sequencer: walks the register pointer over a valid/ready stream and counts parity-error beats.
module recovery_restore_fsm
    import riscv_tmr_pkg::*;
#(
    parameter int NREGS   = NREGS_D,
    parameter int AW      = $clog2(NREGS),
    parameter int SKIP_X0 = 1,
    parameter int CNTW    = 8
) (
    input  logic            clk,
    input  logic            rst_in,
    input  logic            restore_req,
    input  logic            rs_ready,
    input  logic            beat_perr,
    output logic [AW-1:0]   ptr,
    output logic            busy,
    output logic            rs_valid,
    output logic            restore_done,
    output logic [CNTW-1:0] perr_count
);

    rec_state_t state;

    always_ff @(posedge clk) begin
        if (rst_in) begin
            state        <= IDLE;
            ptr          <= '0;
            busy         <= 1'b0;
            rs_valid     <= 1'b0;
            restore_done <= 1'b0;
            perr_count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    restore_done <= 1'b0;
                    if (restore_req) begin
                        ptr      <= (SKIP_X0 != 0) ? AW'(1) : '0;
                        state    <= RESTORE;
                        busy     <= 1'b1;
                        rs_valid <= 1'b1;
                    end
                end
                RESTORE: begin
                    if (rs_ready) begin
                        if (beat_perr && perr_count != {CNTW{1'b1}})
                            perr_count <= perr_count + 1'b1;
                        // The pointer parks on the last entry rather than wrapping.
                        if (ptr == AW'(NREGS - 1)) begin
                            state        <= DONE;
                            rs_valid     <= 1'b0;
                            restore_done <= 1'b1;
                        end else begin
                            ptr <= ptr + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state        <= IDLE;
                    busy         <= 1'b0;
                    restore_done <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    rs_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/recovery_regfile_ckpt.sv
// Shadow register file with per-entry parity, write-first read ports and a streamed restore path.
module recovery_regfile_ckpt
    import riscv_tmr_pkg::*;
#(
    parameter int XLEN    = XLEN_D,
    parameter int NREGS   = NREGS_D,
    parameter int AW      = $clog2(NREGS),
    parameter int SKIP_X0 = 1,
    parameter int CNTW    = 8
) (
    input  logic            clk,
    input  logic            rst_in,
    input  logic            we,
    input  logic [AW-1:0]   wa,
    input  logic [XLEN-1:0] wd,
    input  logic            err_inj,
    input  logic [AW-1:0]   ra1,
    input  logic [AW-1:0]   ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    output logic            rperr1,
    output logic            rperr2,
    input  logic            restore_req,
    output logic            rs_valid,
    input  logic            rs_ready,
    output logic [AW-1:0]   rs_addr,
    output logic [XLEN-1:0] rs_data,
    output logic            rs_perr,
    output logic            busy,
    output logic            restore_done,
    output logic            wr_dropped,
    output logic [CNTW-1:0] perr_count
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] par;
    logic [AW-1:0]    ptr;

    // Writes are frozen while the restore is streaming so the image stays consistent.
    always_ff @(posedge clk) begin
        if (rst_in) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            par <= '0;
        end else if (we && !busy && wa != '0) begin
            regs[wa] <= wd;
            par[wa]  <= even_par(wd) ^ err_inj;
        end
    end

    assign wr_dropped = we & busy;

    always_comb begin
        rd1    = '0;
        rperr1 = 1'b0;
        if (ra1 != '0) begin
            if (we && !busy && wa == ra1) begin
                rd1 = wd;
            end else begin
                rd1    = regs[ra1];
                rperr1 = even_par(regs[ra1]) ^ par[ra1];
            end
        end
    end

    always_comb begin
        rd2    = '0;
        rperr2 = 1'b0;
        if (ra2 != '0) begin
            if (we && !busy && wa == ra2) begin
                rd2 = wd;
            end else begin
                rd2    = regs[ra2];
                rperr2 = even_par(regs[ra2]) ^ par[ra2];
            end
        end
    end

    assign rs_addr = ptr;
    assign rs_data = regs[ptr];
    assign rs_perr = rs_valid & (even_par(regs[ptr]) ^ par[ptr]);

    recovery_restore_fsm #(
        .NREGS  (NREGS),
        .AW     (AW),
        .SKIP_X0(SKIP_X0),
        .CNTW   (CNTW)
    ) u_fsm (
        .clk         (clk),
        .rst_in      (rst_in),
        .restore_req (restore_req),
        .rs_ready    (rs_ready),
        .beat_perr   (rs_perr),
        .ptr         (ptr),
        .busy        (busy),
        .rs_valid    (rs_valid),
        .restore_done(restore_done),
        .perr_count  (perr_count)
    );

endmodule
